otter_regfile_sb: RTL
=====================

# otter_regfile_sb

Parametrised multi-read-port register file with an integrated write-reservation scoreboard, for the pipelined OTTER core. Supplies operands to decode/issue, tracks which architectural registers have an in-flight producer, and can forward same-cycle writeback data. Replaces the fixed 2-read, 32×32 register file in pipelined configurations.

## Interface
Parameters:
- XLEN, 32, data width per register
- DEPTH, 32, number of registers; power of two, ≥2
- NUM_READ, 2, number of read ports, 1–4
- BYPASS, 1, 1 = same-cycle write-to-read forwarding; 0 = no forwarding

AW = $clog2(DEPTH).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- rd_addr  in  NUM_READ*AW  read addresses; port i = bits [i*AW +: AW]
- rd_data  out  NUM_READ*XLEN  read data, port i = [i*XLEN +: XLEN]
- rd_busy  out  NUM_READ  port i's register has an outstanding reservation
- wr_en  in  1  writeback strobe; also releases the reservation
- wr_addr  in  AW  writeback register
- wr_data  in  XLEN  writeback data
- rsv_en  in  1  request to reserve rsv_addr for an in-flight producer
- rsv_addr  in  AW  register to reserve
- rsv_ok  out  1  reservation accepted this cycle
- busy_count  out  AW+1  number of currently reserved registers

## Operation
- Register 0 is hardwired zero: never written, never busy; rd_data = 0 and rd_busy = 0 for address 0; rsv_ok = 1 for rsv_addr = 0 with no state change.
- Write: on a clock edge with wr_en = 1 and wr_addr ≠ 0, RF[wr_addr] ← wr_data and busy[wr_addr] ← 0.
- Reserve: rsv_ok = rsv_en & (rsv_addr == 0 | ~busy[rsv_addr] | (wr_en & wr_addr == rsv_addr)). When rsv_ok and rsv_addr ≠ 0, busy[rsv_addr] ← 1 at the edge. A rejected reserve changes nothing; the requester stalls and retries.
- Simultaneous write and reserve to the same nonzero register: data written, busy ends at 1 (new producer wins), rsv_ok = 1.
- Write to a non-busy register is legal: data written, busy stays 0.
- Read, BYPASS = 1: when wr_en and wr_addr == rd_addr[i] ≠ 0, rd_data[i] = wr_data and rd_busy[i] = 0. Otherwise RF and busy values.
- Read, BYPASS = 0: always stored RF and busy values.
- busy_count: registered. Incremented on an accepted nonzero reserve of a non-busy register; decremented on a write to a busy register; unchanged when both occur on the same register or neither applies; otherwise net of the two. Never exceeds DEPTH−1.

## Timing
- Reset (async assert, sync-safe release): all RF entries = 0, all busy = 0, busy_count = 0. Combinational outputs follow from the cleared state immediately; rsv_ok depends only on current inputs.
- Reads, rd_busy and rsv_ok are combinational, with zero latency.
- Write and reserve take effect at the next rising edge. Without bypass, new data is visible the cycle after wr_en.
- Reset asserted mid-operation discards all reservations and data in the same cycle. No reservation survives reset.

## Structure
- Package otter_rf_pkg: default XLEN/DEPTH constants and typedef rf_addr_t (logic [AW-1:0]) shared with decode/hazard units.
- Sub-module otter_rf_scoreboard: busy vector, rsv_ok logic and busy_count. The data array, bypass muxes and read ports stay in the top level.

## Test plan
- Reset, then read all 32 addresses on both ports → rd_data = 0, rd_busy = 0, busy_count = 0.
- Write x5 = 0xDEADBEEF; next cycle read rd_addr0 = 5 → 0xDEADBEEF. Write x0 = 0x1234 → x0 still reads 0.
- BYPASS = 1: wr_en with x7 = 0xA5A5A5A5 while reading x7 in the same cycle → rd_data = 0xA5A5A5A5. BYPASS = 0 → old value 0.
- Reserve x3 → rsv_ok = 1, next cycle rd_busy = 1, busy_count = 1. Reserve x3 again → rsv_ok = 0, count stays 1. Write x3 → busy clears, count = 0.
- Same cycle: write x3 and reserve x3 while x3 is busy → rsv_ok = 1, data updated, x3 still busy, busy_count unchanged.
- Reserve x1, x2, x4; assert reset asynchronously between edges → busy_count = 0 and all busy = 0 immediately; RF reads 0.

Source files
------------

// File: rtl/otter_rf_pkg.sv
// otter_rf_pkg: default register-file geometry and the shared register-address type
package otter_rf_pkg;
  localparam int RF_XLEN = 32;
  localparam int RF_DEPTH = 32;
  localparam int RF_AW = $clog2(RF_DEPTH);
  typedef logic [RF_AW-1:0] rf_addr_t;
endpackage

// File: rtl/otter_rf_scoreboard.sv
// otter_rf_scoreboard: per-register reservation bits, reserve acceptance and busy count
module otter_rf_scoreboard
  import otter_rf_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic [DEPTH-1:0] busy,
  output logic             rsv_ok,
  output logic [AW:0]      busy_count
);
  logic inc, dec;
  // a write that is immediately re-reserved leaves the register busy, so it must not count down
  always_comb begin
    rsv_ok = rsv_en & ((rsv_addr == '0) | ~busy[rsv_addr] | (wr_en & (wr_addr == rsv_addr)));
    inc = rsv_ok & (rsv_addr != '0) & ~busy[rsv_addr];
    dec = wr_en & (wr_addr != '0) & busy[wr_addr] & ~(rsv_ok & (rsv_addr == wr_addr));
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy <= '0;
      busy_count <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++)
        if (rsv_ok && rsv_addr == AW'(i)) busy[i] <= 1'b1;
        else if (wr_en && wr_addr == AW'(i)) busy[i] <= 1'b0;
      busy_count <= busy_count + (AW+1)'(inc) - (AW+1)'(dec);
    end
  end
endmodule

// File: rtl/otter_regfile_sb.sv
// otter_regfile_sb: multi-port register file with write-reservation scoreboard
// and optional same-cycle writeback forwarding
module otter_regfile_sb
  import otter_rf_pkg::*;
#(
  parameter int XLEN = RF_XLEN,
  parameter int DEPTH = RF_DEPTH,
  parameter int NUM_READ = 2,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_READ*AW-1:0]   rd_addr,
  output logic [NUM_READ*XLEN-1:0] rd_data,
  output logic [NUM_READ-1:0]      rd_busy,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [XLEN-1:0]          wr_data,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr,
  output logic                     rsv_ok,
  output logic [AW:0]              busy_count
);
  logic [XLEN-1:0] rf [DEPTH];
  logic [DEPTH-1:0] busy;

  otter_rf_scoreboard #(.DEPTH(DEPTH), .AW(AW)) u_sb (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy), .rsv_ok(rsv_ok),
    .busy_count(busy_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    else if (wr_en && wr_addr != '0) rf[wr_addr] <= wr_data;
  end

  for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
    logic [AW-1:0] a;
    logic hit;
    always_comb begin
      a = rd_addr[g*AW +: AW];
      hit = (BYPASS != 0) && wr_en && (wr_addr == a);
      rd_data[g*XLEN +: XLEN] = (a == '0) ? '0 : hit ? wr_data : rf[a];
      rd_busy[g] = (a != '0) && !hit && busy[a];
    end
  end
endmodule
